// File: rtl/cla_pkg.sv
// Shared constants and width helpers for the two-level carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_BLOCK_W = 4;

  // Operand width rounded up to a whole number of lookahead blocks.
  function automatic int unsigned cla_pad_width(int unsigned width);
    return ((width + CLA_BLOCK_W - 1) / CLA_BLOCK_W) * CLA_BLOCK_W;
  endfunction

  function automatic int unsigned cla_num_blocks(int unsigned width);
    return (width + CLA_BLOCK_W - 1) / CLA_BLOCK_W;
  endfunction

endpackage

// File: rtl/cla_block4.sv
// 4-bit carry-lookahead block: internal carries from cin, plus group generate/propagate
// for the second-level lookahead unit.
module cla_block4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       g_o,
  output logic       p_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

  assign s_o = p ^ c;

  // Group terms deliberately exclude cin so the upper level never loops back through a block.
  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o = &p;

endmodule

// File: rtl/carry_lookahead_adder.sv
// Unsigned WIDTH-bit adder with 4-bit lookahead blocks, a second-level lookahead unit and a
// registered WIDTH+1-bit sum (carry-out in the MSB).
module carry_lookahead_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] addend_0,
  input  logic [WIDTH-1:0] addend_1,
  output logic [WIDTH:0]   sum
);

  localparam int unsigned PadW   = cla_pad_width(WIDTH);
  localparam int unsigned NumBlk = cla_num_blocks(WIDTH);

  logic [PadW-1:0] a_pad;
  logic [PadW-1:0] b_pad;
  logic [PadW-1:0] s_pad;
  logic [NumBlk-1:0] grp_g;
  logic [NumBlk-1:0] grp_p;
  logic [NumBlk:0]   blk_c;
  logic [PadW:0]     ext;
  logic              unused_ext;
  logic [WIDTH:0]    sum_d;
  logic [WIDTH:0]    sum_q;

  always_comb begin
    a_pad = '0;
    b_pad = '0;
    a_pad[WIDTH-1:0] = addend_0;
    b_pad[WIDTH-1:0] = addend_1;
  end

  for (genvar i = 0; i < NumBlk; i++) begin : g_blk
    cla_block4 u_blk (
      .a_i  (a_pad[i*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .b_i  (b_pad[i*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .cin_i(blk_c[i]),
      .s_o  (s_pad[i*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .g_o  (grp_g[i]),
      .p_o  (grp_p[i])
    );
  end

  // Second level: every block carry is a flat sum of products of G/P, with c0 = 0.
  always_comb begin
    blk_c = '0;
    for (int j = 0; j < int'(NumBlk); j++) begin
      logic acc;
      acc = 1'b0;
      for (int k = 0; k <= j; k++) begin
        logic term;
        term = grp_g[k];
        for (int m = k + 1; m <= j; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      blk_c[j+1] = acc;
    end
  end

  // Pad bits are zero, so bit WIDTH of the padded sum is exactly the carry out of bit WIDTH-1;
  // when WIDTH fills the last block that bit is the final block carry.
  assign ext        = {blk_c[NumBlk], s_pad};
  assign sum_d      = ext[WIDTH:0];
  assign unused_ext = ^ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench: directed and random sums at several widths against plain arithmetic.
module tb_carry_lookahead_adder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [8:0]  a9,  b9;
  logic [9:0]  s9;
  logic [0:0]  a1,  b1;
  logic [1:0]  s1;
  logic [3:0]  a4,  b4;
  logic [4:0]  s4;
  logic [7:0]  a8,  b8;
  logic [8:0]  s8;
  logic [12:0] a13, b13;
  logic [13:0] s13;

  carry_lookahead_adder #(.WIDTH(9)) u_dut9 (
    .clk(clk), .reset_n(reset_n), .addend_0(a9), .addend_1(b9), .sum(s9));
  carry_lookahead_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .addend_0(a1), .addend_1(b1), .sum(s1));
  carry_lookahead_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .addend_0(a4), .addend_1(b4), .sum(s4));
  carry_lookahead_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .addend_0(a8), .addend_1(b8), .sum(s8));
  carry_lookahead_adder #(.WIDTH(13)) u_dut13 (
    .clk(clk), .reset_n(reset_n), .addend_0(a13), .addend_1(b13), .sum(s13));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: zero-extended a + b, reduced modulo 2^(w+1).
  function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return ((a & m) + (b & m)) & ((64'd1 << (w + 1)) - 64'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned da [8] = '{3, 100, 0, 511, 255, 15, 511, 256};
  int unsigned db [8] = '{4,  27, 0,   1,   1,  1, 511, 256};

  initial begin
    reset_n = 1'b1;
    a9 = 9'd100; b9 = 9'd50;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0; a13 = '0; b13 = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_w9", 64'(s9), 64'd0);
    chk("rst_async_w13", 64'(s13), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_hold_w9_%0d", i), 64'(s9), 64'd0);
    end
    #2 reset_n = 1'b1;
    tick();
    chk("rst_release", 64'(s9), 64'd150);

    // Back-to-back directed pairs, including block-boundary and full carry chains.
    for (int i = 0; i < 8; i++) begin
      a9 = 9'(da[i]);
      b9 = 9'(db[i]);
      tick();
      chk($sformatf("dir_%0d+%0d", da[i], db[i]), 64'(s9), ref_add(64'(da[i]), 64'(db[i]), 9));
    end
    chk("dir_max_const", 64'(s9), 64'd512);

    for (int i = 0; i < 20; i++) begin
      a9 = 9'($urandom());
      b9 = 9'($urandom());
      tick();
      chk($sformatf("rnd_w9_%0d", i), 64'(s9), ref_add(64'(a9), 64'(b9), 9));
    end

    // Asynchronous reset between edges discards the pending result.
    a9 = 9'd300; b9 = 9'd200;
    tick();
    chk("mid_pre", 64'(s9), 64'd500);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_async_clear", 64'(s9), 64'd0);
    a9 = 9'd10; b9 = 9'd20;
    tick();
    chk("mid_hold", 64'(s9), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("mid_resume", 64'(s9), 64'd30);

    // Width sweep: all-ones + all-ones, all-ones + 1, then random.
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        a1 = '1; b1 = '1; a4 = '1; b4 = '1; a8 = '1; b8 = '1; a13 = '1; b13 = '1;
      end else if (i == 1) begin
        a1 = '1; b1 = 1'd1; a4 = '1; b4 = 4'd1; a8 = '1; b8 = 8'd1; a13 = '1; b13 = 13'd1;
      end else begin
        a1  = 1'($urandom());  b1  = 1'($urandom());
        a4  = 4'($urandom());  b4  = 4'($urandom());
        a8  = 8'($urandom());  b8  = 8'($urandom());
        a13 = 13'($urandom()); b13 = 13'($urandom());
      end
      tick();
      chk($sformatf("sw_w1_%0d", i), 64'(s1), ref_add(64'(a1), 64'(b1), 1));
      chk($sformatf("sw_w4_%0d", i), 64'(s4), ref_add(64'(a4), 64'(b4), 4));
      chk($sformatf("sw_w8_%0d", i), 64'(s8), ref_add(64'(a8), 64'(b8), 8));
      chk($sformatf("sw_w13_%0d", i), 64'(s13), ref_add(64'(a13), 64'(b13), 13));
      if (i == 0) begin
        chk("sw_w1_1p1", 64'(s1), 64'd2);
        chk("sw_w13_ones", 64'(s13), 64'd16382);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
